servo_frame_scheduler: RTL and testbench
========================================

Name: servo_frame_scheduler

Overview:
Time-shares one slew/step datapath across NUM_CH hobby-servo channels, all driven from a single 1 MHz tick.
- Each 20 ms frame: walks every channel's current position one step toward its commanded target, then generates all PWM pulses from one shared frame counter.
- Sits between the user/command logic (switch decoder, UART front end) and the servo header pins.
- Provides a per-channel status word for the display path.

Parameters:
NUM_CH, 4, number of servo channels (2..8)
FRAME_TICKS, 20000, mclk ticks per PWM frame (20 ms at 1 MHz)
PULSE_BASE, 500, pulse width in ticks at position 0; must exceed NUM_CH
POS_MAX, 2200, maximum position value; pulse = PULSE_BASE + pos
STEP, 10, maximum position change per channel per frame

Ports:
mclk  in  1  1 MHz system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; transfer occurs when cmd_valid && cmd_ready
cmd_ch  in  3  target channel index; indices >= NUM_CH are accepted and discarded
cmd_pos  in  12  target position
freeze  in  NUM_CH  per-channel hold; frozen channel does not step
status_ch  in  3  channel selected for status_word
pwm_out  out  NUM_CH  servo pulse outputs
frame_start  out  1  one-cycle pulse when frame counter == 0
moving  out  NUM_CH  bit i = cur[i] != tgt[i]
status_word  out  16  {status_ch[1:0], moving[sel], freeze[sel], cur[sel][11:0]}

Behaviour:
- Reset (rst_n=0 at posedge): counter=0, all cur=0, all tgt=0, state=UPD, idx=0, pwm_out=0, frame_start=0, cmd_ready=0. Reset mid-frame or mid-update discards everything and returns to these values.
- Frame counter: 15 bits, counts 0..FRAME_TICKS-1, wraps to 0. frame_start is registered and is high for exactly the cycle the counter equals 0.
- FSM states RUN and UPD:
  - RUN -> UPD when the counter wraps to 0; idx=0.
  - UPD: processes channel idx in one cycle, idx++. After idx==NUM_CH-1, -> RUN. UPD therefore occupies counter values 0..NUM_CH-1.
- Step rule for channel idx in UPD:
  - freeze[idx]=1 or cur==tgt: cur holds.
  - Otherwise cur moves toward tgt by min(STEP, |tgt-cur|). Never overshoots; exact landing on tgt.
  - Subtraction is done unsigned, comparing first; no wrap below 0 or above POS_MAX.
- Command handshake:
  - cmd_ready = (state==RUN), registered. cmd_ready is low during reset and UPD.
  - On transfer, tgt[cmd_ch] <= min(cmd_pos, POS_MAX).
  - A command accepted in the last RUN cycle (counter==FRAME_TICKS-1) is used by the immediately following UPD.
  - Only one command is accepted per cycle. A channel's cur never changes outside its own UPD cycle.
- PWM:
  - pwm_out[i] registered = (counter < PULSE_BASE + cur[i]). Compare width is 15 bits.
  - Because PULSE_BASE > NUM_CH, every pwm_out is high throughout UPD, so cur changes cause no glitch or partial pulse.
  - Pulse width equals PULSE_BASE+cur in ticks. pwm_out is delayed one cycle relative to the counter.
- Retarget mid-ramp: the new tgt takes effect at the next UPD; direction may reverse.
- moving and status_word are combinational from registers. An out-of-range status_ch returns 0.

Decomposition:
- Shared package servo_pkg:
  - FRAME_TICKS, PULSE_BASE, POS_MAX, STEP defaults.
  - POS_W=12, CNT_W=15.
  - State enum {RUN, UPD}.
  - status_word field offsets.
- One sub-module: servo_step_unit, the combinational cur/tgt/freeze -> next_cur stepper. It is instantiated once and shared by idx muxing, which is the point of the scheduler.

Test Plan:
- Release reset, no commands -> every pwm_out high for exactly 500 ticks per 20000-tick frame; frame_start every 20000 cycles; cmd_ready low for counter 0..3.
- Command ch1 pos 1000 -> cur[1] +10 per frame, moving[1]=1 for 100 frames, then pulse width 1500 ticks and moving[1]=0; other channels stay at 500.
- Command ch2 pos 3000 -> tgt clamped 2200; after 220 frames pulse 2700; status_ch=2 gives cur field 2200.
- ch0 at 1005, command pos 0 -> steps down by 10 then final step 5, lands exactly 0, no underflow.
- ch3 ramping toward 2000, assert freeze[3] for 5 frames -> cur[3] constant, pulse width constant; ramp resumes after release.
- cmd_valid asserted at counter==1 (UPD) -> held off until counter==4, then accepted; command at counter==19999 is applied at that frame's UPD; rst_n=0 mid-ramp -> all cur/tgt 0 next cycle.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants and types for the servo frame scheduler.
// The defaults give 20 ms frames on a 1 MHz tick.
package servo_pkg;

  localparam int unsigned FrameTicksDflt = 20000;
  localparam int unsigned PulseBaseDflt  = 500;
  localparam int unsigned PosMaxDflt     = 2200;
  localparam int unsigned StepDflt       = 10;

  localparam int unsigned POS_W = 12;
  localparam int unsigned CNT_W = 15;

  typedef enum logic {
    RUN,
    UPD
  } state_e;

  // status_word layout: {ch[1:0], moving, freeze, cur[11:0]}
  localparam int unsigned SwCurLsb = 0;
  localparam int unsigned SwFrzBit = 12;
  localparam int unsigned SwMovBit = 13;
  localparam int unsigned SwChLsb  = 14;

endpackage

// File: rtl/servo_step_unit.sv
// Combinational stepper: moves cur toward tgt by at most STEP, landing exactly on tgt.
// Shared by all channels through the scheduler's index mux.
module servo_step_unit
  import servo_pkg::*;
#(
  parameter int unsigned STEP = StepDflt
) (
  input  logic [POS_W-1:0] cur_i,
  input  logic [POS_W-1:0] tgt_i,
  input  logic             freeze_i,
  output logic [POS_W-1:0] next_cur_o
);

  localparam logic [POS_W-1:0] StepW = POS_W'(STEP);

  logic [POS_W-1:0] diff;

  // Compare first so the unsigned difference never wraps.
  always_comb begin
    next_cur_o = cur_i;
    diff       = '0;
    if (!freeze_i && (cur_i != tgt_i)) begin
      if (tgt_i > cur_i) begin
        diff       = tgt_i - cur_i;
        next_cur_o = (diff > StepW) ? cur_i + StepW : tgt_i;
      end else begin
        diff       = cur_i - tgt_i;
        next_cur_o = (diff > StepW) ? cur_i - StepW : tgt_i;
      end
    end
  end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Multi-channel servo PWM generator: one shared frame counter and one shared stepper,
// time-multiplexed across channels during the first NUM_CH cycles of every frame.
module servo_frame_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned FRAME_TICKS = FrameTicksDflt,
  parameter int unsigned PULSE_BASE  = PulseBaseDflt,
  parameter int unsigned POS_MAX     = PosMaxDflt,
  parameter int unsigned STEP        = StepDflt
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_ch,
  input  logic [11:0]       cmd_pos,
  input  logic [NUM_CH-1:0] freeze,
  input  logic [2:0]        status_ch,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic [NUM_CH-1:0] moving,
  output logic [15:0]       status_word
);

  localparam logic [CNT_W-1:0] FrameLast  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] PulseBaseW = CNT_W'(PULSE_BASE);
  localparam logic [POS_W-1:0] PosMaxW    = POS_W'(POS_MAX);
  localparam logic [2:0]       IdxLast    = 3'(NUM_CH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [POS_W-1:0] cur_q [NUM_CH];
  logic [POS_W-1:0] tgt_q [NUM_CH];
  logic [NUM_CH-1:0] pwm_q;
  logic             frame_start_q;
  logic             cmd_ready_q;

  logic             cmd_fire;
  logic [POS_W-1:0] cmd_pos_clamped;
  logic [POS_W-1:0] sel_cur, sel_tgt, step_next;
  logic             sel_frz;

  always_comb begin
    cnt_d   = (cnt_q == FrameLast) ? '0 : cnt_q + CNT_W'(1);
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      RUN: begin
        if (cnt_q == FrameLast) begin
          state_d = UPD;
          idx_d   = '0;
        end
      end
      UPD: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == IdxLast) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign cmd_fire        = cmd_valid && cmd_ready_q;
  assign cmd_pos_clamped = (cmd_pos > PosMaxW) ? PosMaxW : cmd_pos;

  // Route the channel being updated into the single shared stepper.
  always_comb begin
    sel_cur = '0;
    sel_tgt = '0;
    sel_frz = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (idx_q == 3'(i)) begin
        sel_cur = cur_q[i];
        sel_tgt = tgt_q[i];
        sel_frz = freeze[i];
      end
    end
  end

  servo_step_unit #(
    .STEP (STEP)
  ) u_step (
    .cur_i      (sel_cur),
    .tgt_i      (sel_tgt),
    .freeze_i   (sel_frz),
    .next_cur_o (step_next)
  );

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q       <= UPD;
      cnt_q         <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_start_q <= (cnt_d == '0);
      cmd_ready_q   <= (state_d == RUN);
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if ((state_q == UPD) && (idx_q == 3'(i))) cur_q[i] <= step_next;
        if (cmd_fire && (cmd_ch == 3'(i))) tgt_q[i] <= cmd_pos_clamped;
        // PULSE_BASE > NUM_CH keeps every output high while cur is being updated.
        pwm_q[i] <= (cnt_q < (PulseBaseW + CNT_W'(cur_q[i])));
      end
    end
  end

  always_comb begin
    moving = '0;
    for (int i = 0; i < int'(NUM_CH); i++) moving[i] = (cur_q[i] != tgt_q[i]);
  end

  always_comb begin
    status_word = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (status_ch == 3'(i)) begin
        status_word[SwChLsb +: 2]      = status_ch[1:0];
        status_word[SwMovBit]          = moving[i];
        status_word[SwFrzBit]          = freeze[i];
        status_word[SwCurLsb +: POS_W] = cur_q[i];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign cmd_ready   = cmd_ready_q;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Bench for servo_frame_scheduler: directed scenarios plus random traffic, all checked
// every cycle against a frame-level arithmetic model of the channel positions.
module tb_servo_frame_scheduler;

  localparam int NCH = 4;
  localparam int FT  = 600;
  localparam int PB  = 20;
  localparam int PM  = 500;
  localparam int ST  = 23;

  logic           mclk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [2:0]     cmd_ch = '0;
  logic [11:0]    cmd_pos = '0;
  logic [NCH-1:0] freeze = '0;
  logic [2:0]     status_ch = '0;
  logic           cmd_ready, frame_start;
  logic [NCH-1:0] pwm_out, moving;
  logic [15:0]    status_word;

  int n_checks = 0;
  int n_fail = 0;

  // Model: mt is the index of the current cycle since reset; the frame counter is mt % FT.
  int             mt = 0;
  int             mcur [NCH];
  int             mtgt [NCH];
  logic [NCH-1:0] mpwm = '0;
  logic           mfs = 1'b0;
  logic           mvalid = 1'b0;
  logic           mfired = 1'b0;

  always #5 mclk = ~mclk;

  servo_frame_scheduler #(
    .NUM_CH      (NCH),
    .FRAME_TICKS (FT),
    .PULSE_BASE  (PB),
    .POS_MAX     (PM),
    .STEP        (ST)
  ) dut (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ch      (cmd_ch),
    .cmd_pos     (cmd_pos),
    .freeze      (freeze),
    .status_ch   (status_ch),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .moving      (moving),
    .status_word (status_word)
  );

  function automatic int step_to(int c, int t, logic frz);
    int d;
    if (frz) return c;
    d = t - c;
    if (d > ST) d = ST;
    if (d < -ST) d = -ST;
    return c + d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want)
    else begin
      n_fail++;
      if (n_fail <= 20) $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] emov;
    logic [15:0]    esw;
    int             sc;
    for (int i = 0; i < NCH; i++) emov[i] = (mcur[i] != mtgt[i]);
    sc  = int'(status_ch);
    esw = '0;
    if (sc < NCH) esw = {status_ch[1:0], emov[sc], freeze[sc], 12'(mcur[sc])};
    check("pwm_out", 32'(pwm_out), 32'(mpwm));
    check("frame_start", 32'(frame_start), 32'(mfs));
    check("cmd_ready", 32'(cmd_ready), 32'((mt % FT) >= NCH));
    check("moving", 32'(moving), 32'(emov));
    check("status_word", 32'(status_word), 32'(esw));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare at negedge.
  task automatic cyc();
    int c;
    @(posedge mclk);
    mfired = 1'b0;
    if (!rst_n) begin
      mt = 0;
      for (int i = 0; i < NCH; i++) begin
        mcur[i] = 0;
        mtgt[i] = 0;
      end
      mpwm   = '0;
      mfs    = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      c = mt % FT;
      for (int i = 0; i < NCH; i++) mpwm[i] = (c < PB + mcur[i]);
      if (c < NCH) mcur[c] = step_to(mcur[c], mtgt[c], freeze[c]);
      if (cmd_valid && (c >= NCH)) begin
        mfired = 1'b1;
        if (int'(cmd_ch) < NCH) mtgt[cmd_ch] = (int'(cmd_pos) > PM) ? PM : int'(cmd_pos);
      end
      mt++;
      mfs = ((mt % FT) == 0);
    end
    @(negedge mclk);
    if (mvalid) compare_all();
  endtask

  task automatic frames(input int n);
    repeat (n * FT) cyc();
  endtask

  task automatic goto_cnt(input int k);
    int n = 0;
    while (((mt % FT) != k) && (n <= FT)) begin
      cyc();
      n++;
    end
  endtask

  task automatic send_cmd(input int ch, input int pos);
    int budget = 0;
    cmd_valid = 1'b1;
    cmd_ch    = 3'(ch);
    cmd_pos   = 12'(pos);
    do begin
      cyc();
      budget++;
    end while (!mfired && (budget < 2 * FT));
    check("cmd_accept_timeout", 32'(mfired), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_cur(input string tag, input int ch, input int want);
    status_ch = 3'(ch);
    #1;
    check(tag, 32'(status_word[11:0]), 32'(want));
  endtask

  task automatic chk_width(input string tag, input int ch, input int want);
    int w = 0;
    for (int k = 0; k < FT; k++) begin
      cyc();
      if (pwm_out[ch]) w++;
    end
    check(tag, 32'(w), 32'(want));
  endtask

  initial begin
    rst_n = 1'b0;
    cyc();
    cyc();
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd0);
    check("reset_fs", 32'(frame_start), 32'd0);
    check("reset_status", 32'(status_word), 32'd0);
    rst_n = 1'b1;

    // Idle: every channel at base width.
    frames(1);
    chk_width("idle_width_ch0", 0, PB);

    // ch1 to 230: ten full steps.
    goto_cnt(100);
    send_cmd(1, 230);
    frames(10);
    chk_cur("ch1_cur", 1, 230);
    check("ch1_moving", 32'(moving[1]), 32'd0);
    chk_width("ch1_width", 1, PB + 230);
    chk_width("ch0_width_unchanged", 0, PB);

    // ch2 target clamps to PM; ch0 up to 100 then back down to exactly 0.
    goto_cnt(100);
    send_cmd(2, 4000);
    send_cmd(0, 100);
    frames(5);
    chk_cur("ch0_up", 0, 100);
    send_cmd(0, 0);
    frames(5);
    chk_cur("ch0_land_zero", 0, 0);
    frames(12);
    chk_cur("ch2_clamped", 2, PM);
    chk_width("ch2_width", 2, PB + PM);

    // ch3 ramps, freezes for five frames, then resumes.
    goto_cnt(100);
    send_cmd(3, 400);
    frames(3);
    chk_cur("ch3_ramp", 3, 69);
    freeze[3] = 1'b1;
    frames(4);
    chk_cur("ch3_frozen", 3, 69);
    chk_width("ch3_frozen_width", 3, PB + 69);
    freeze[3] = 1'b0;
    frames(1);
    chk_cur("ch3_resumed", 3, 92);

    // Request during UPD is held off until counter reaches NCH.
    goto_cnt(1);
    cmd_valid = 1'b1;
    cmd_ch    = 3'd3;
    cmd_pos   = 12'd92;
    for (int k = 1; k < NCH; k++) begin
      check("ready_held_low", 32'(cmd_ready), 32'd0);
      cyc();
    end
    check("ready_after_upd", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;

    // Command in the last RUN cycle feeds the very next UPD.
    goto_cnt(FT - 1);
    send_cmd(1, 0);
    repeat (NCH) cyc();
    chk_cur("late_cmd_step", 1, 207);

    // Reset mid-ramp clears every position and target.
    rst_n = 1'b0;
    cyc();
    for (int i = 0; i < NCH; i++) chk_cur("midreset_cur", i, 0);
    check("midreset_moving", 32'(moving), 32'd0);
    rst_n = 1'b1;

    // Random commands, freezes and status selects.
    for (int k = 0; k < 25 * FT; k++) begin
      if (!cmd_valid && ($urandom_range(0, 149) == 0)) begin
        cmd_valid = 1'b1;
        cmd_ch    = 3'($urandom_range(0, 7));
        cmd_pos   = 12'($urandom_range(0, 4095));
      end
      if (((mt % FT) == FT / 2) && ($urandom_range(0, 3) == 0)) freeze = NCH'($urandom);
      status_ch = 3'($urandom_range(0, 7));
      cyc();
      if (mfired) cmd_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
